// File: rtl/axi_wr_arb2_if.sv
// Bundled AW/W/B signals of the 2:1 write arbiter: two master-side ports (s_*) and one slave-side port (m_*).
// Modport master is the arbiter's view; modport slave is the view of the surrounding masters and memory.
interface axi_wr_arb2_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  localparam int AWP = ID_WIDTH + ADDR_WIDTH + 13;
  localparam int WP  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int BP  = ID_WIDTH + 2;

  logic [2*AWP-1:0] s_aw_pld;
  logic [1:0]       s_aw_valid;
  logic [1:0]       s_aw_ready;
  logic [2*WP-1:0]  s_w_pld;
  logic [1:0]       s_w_valid;
  logic [1:0]       s_w_ready;
  logic [BP-1:0]    s_b_pld;
  logic [1:0]       s_b_valid;
  logic [1:0]       s_b_ready;
  logic [AWP:0]     m_aw_pld;
  logic             m_aw_valid;
  logic             m_aw_ready;
  logic [WP-1:0]    m_w_pld;
  logic             m_w_valid;
  logic             m_w_ready;
  logic [BP:0]      m_b_pld;
  logic             m_b_valid;
  logic             m_b_ready;

  modport master (
    input  s_aw_pld, s_aw_valid, s_w_pld, s_w_valid, s_b_ready,
    input  m_aw_ready, m_w_ready, m_b_pld, m_b_valid,
    output s_aw_ready, s_w_ready, s_b_pld, s_b_valid,
    output m_aw_pld, m_aw_valid, m_w_pld, m_w_valid, m_b_ready
  );

  modport slave (
    output s_aw_pld, s_aw_valid, s_w_pld, s_w_valid, s_b_ready,
    output m_aw_ready, m_w_ready, m_b_pld, m_b_valid,
    input  s_aw_ready, s_w_ready, s_b_pld, s_b_valid,
    input  m_aw_pld, m_aw_valid, m_w_pld, m_w_valid, m_b_ready
  );
endinterface

// File: rtl/axi_wr_arb2.sv
// 2:1 round-robin AXI write arbiter, one transaction outstanding; AW is registered (1 cycle), W/B pass through.
// Backpressure: s_aw_ready only in IDLE; W and B readies follow the slave/master for the latched grant only.
module axi_wr_arb2 #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axi_wr_arb2_if.master       bus,
  output logic                busy,
  output logic                proto_err
);
  localparam int AWP = ID_WIDTH + ADDR_WIDTH + 13;
  localparam int WP  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int BP  = ID_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t         state;
  logic           g;
  logic           last_grant;
  logic [AWP:0]   aw_q;
  logic           aw_vld_q;
  logic [7:0]     cnt;

  logic           pick;
  logic           aw_take;
  logic [AWP-1:0] aw_sel;
  logic [WP-1:0]  w_sel;
  logic           w_vld_sel;
  logic           w_last;
  logic           w_hs;
  logic           in_data;
  logic           in_resp;
  logic           b_rdy_sel;
  logic           b_hs;

  always_comb begin
    case (bus.s_aw_valid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~last_grant;
    endcase
  end

  // No AW is accepted while reset is held, so nothing can be lost across the reset edge.
  assign aw_take        = (state == IDLE) && (|bus.s_aw_valid) && !ARESET;
  assign aw_sel         = pick ? bus.s_aw_pld[2*AWP-1:AWP] : bus.s_aw_pld[AWP-1:0];
  assign bus.s_aw_ready = aw_take ? (pick ? 2'b10 : 2'b01) : 2'b00;
  assign bus.m_aw_valid = aw_vld_q;
  assign bus.m_aw_pld   = aw_q;

  assign in_data       = (state == DATA);
  assign w_sel         = g ? bus.s_w_pld[2*WP-1:WP] : bus.s_w_pld[WP-1:0];
  assign w_vld_sel     = g ? bus.s_w_valid[1] : bus.s_w_valid[0];
  assign w_last        = w_sel[0];
  assign bus.m_w_pld   = w_sel;
  assign bus.m_w_valid = in_data && w_vld_sel;
  assign bus.s_w_ready = {in_data && g && bus.m_w_ready, in_data && !g && bus.m_w_ready};
  assign w_hs          = in_data && w_vld_sel && bus.m_w_ready;

  // B is steered by the latched grant; the bid MSB is only cross-checked.
  assign in_resp       = (state == RESP);
  assign b_rdy_sel     = g ? bus.s_b_ready[1] : bus.s_b_ready[0];
  assign bus.m_b_ready = in_resp && b_rdy_sel;
  assign bus.s_b_valid = {in_resp && g && bus.m_b_valid, in_resp && !g && bus.m_b_valid};
  assign bus.s_b_pld   = bus.m_b_pld[BP-1:0];
  assign b_hs          = in_resp && bus.m_b_valid && b_rdy_sel;

  assign busy = (state != IDLE);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      g          <= 1'b0;
      last_grant <= 1'b1;
      aw_q       <= '0;
      aw_vld_q   <= 1'b0;
      cnt        <= 8'd0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_take) begin
            g        <= pick;
            aw_q     <= {pick, aw_sel};
            aw_vld_q <= 1'b1;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (bus.m_aw_ready) begin
            aw_vld_q <= 1'b0;
            cnt      <= aw_q[12:5];
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            cnt <= cnt - 8'd1;
            if (w_last != (cnt == 8'd0)) proto_err <= 1'b1;
            if (w_last) state <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            if (bus.m_b_pld[BP] != g) proto_err <= 1'b1;
            last_grant <= g;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_wr_arb2.sv
// Directed bench for axi_wr_arb2: arbitration order, W routing/backpressure, beat-count errors, async reset.
module tb_axi_wr_arb2;
  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;
  localparam int AWP = ID_WIDTH + ADDR_WIDTH + 13;
  localparam int WP  = DATA_WIDTH + DATA_WIDTH / 8 + 1;

  logic ACLK = 1'b0;
  logic ARESET;
  logic busy;
  logic proto_err;
  int   checks   = 0;
  int   failures = 0;

  axi_wr_arb2_if #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  axi_wr_arb2 #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .bus       (bus),
    .busy      (busy),
    .proto_err (proto_err)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AWP-1:0] mk_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    return {id, addr, len, 3'd3, 2'd1};
  endfunction

  function automatic logic [WP-1:0] mk_w(input logic [63:0] data, input logic last);
    return {data, 8'hFF, last};
  endfunction

  // Full transaction for master m; wlast is driven on beat index last_at.
  task automatic do_txn(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input int last_at, input logic bid_msb, input bit toggle, input logic exp_perr);
    logic [AWP-1:0] awp;
    logic [WP-1:0]  wv;
    logic [1:0]     one_hot;
    logic [1:0]     resp;
    logic           mb;
    logic           mwr;
    int             beat;
    int             cyc;
    awp     = mk_aw(id, addr, len);
    mb      = (m == 1);
    one_hot = mb ? 2'b10 : 2'b01;
    resp    = mb ? 2'b10 : 2'b00;
    if (mb) bus.s_aw_pld[2*AWP-1:AWP] = awp;
    else    bus.s_aw_pld[AWP-1:0]     = awp;
    bus.s_aw_valid[m] = 1'b1;
    #1;
    chk("aw_ready_grant", bus.s_aw_ready, one_hot);
    @(posedge ACLK); #1;
    bus.s_aw_valid[m] = 1'b0;
    chk("m_aw_valid", bus.m_aw_valid, 1'b1);
    chk("m_aw_pld", bus.m_aw_pld, {mb, awp});
    chk("aw_ready_busy", bus.s_aw_ready, 2'b00);
    chk("busy_addr", busy, 1'b1);
    bus.m_aw_ready = 1'b0;
    @(posedge ACLK); #1;
    chk("m_aw_hold", bus.m_aw_pld, {mb, awp});
    bus.m_aw_ready = 1'b1;
    @(posedge ACLK); #1;
    bus.m_aw_ready = 1'b0;
    chk("m_aw_drop", bus.m_aw_valid, 1'b0);

    beat = 0;
    cyc  = 0;
    while (beat <= last_at && cyc < 64) begin
      wv = mk_w(64'hD000 + 64'(m * 256 + beat), beat == last_at);
      if (mb) begin
        bus.s_w_pld[2*WP-1:WP] = wv;
        bus.s_w_pld[WP-1:0]    = mk_w(64'hBAD0, 1'b1);
      end else begin
        bus.s_w_pld[WP-1:0]    = wv;
        bus.s_w_pld[2*WP-1:WP] = mk_w(64'hBAD1, 1'b1);
      end
      bus.s_w_valid = 2'b11;
      mwr = toggle ? (cyc % 2 == 1) : 1'b1;
      bus.m_w_ready = mwr;
      #1;
      chk("m_w_valid", bus.m_w_valid, 1'b1);
      chk("m_w_pld", bus.m_w_pld, wv);
      chk("s_w_ready", bus.s_w_ready, mwr ? one_hot : 2'b00);
      @(posedge ACLK); #1;
      if (mwr) beat++;
      cyc++;
    end
    chk("w_beats", 32'(beat), 32'(last_at + 1));
    bus.s_w_valid = 2'b00;
    bus.m_w_ready = 1'b0;

    bus.m_b_pld   = {bid_msb, id, resp};
    bus.m_b_valid = 1'b1;
    bus.s_b_ready = 2'b00;
    #1;
    chk("w_ready_resp", bus.s_w_ready, 2'b00);
    chk("s_b_valid", bus.s_b_valid, one_hot);
    chk("s_b_pld", bus.s_b_pld, {id, resp});
    chk("m_b_ready_low", bus.m_b_ready, 1'b0);
    @(posedge ACLK); #1;
    bus.s_b_ready[m] = 1'b1;
    #1;
    chk("m_b_ready", bus.m_b_ready, 1'b1);
    @(posedge ACLK); #1;
    bus.m_b_valid = 1'b0;
    bus.s_b_ready = 2'b00;
    chk("busy_done", busy, 1'b0);
    chk("proto_err", proto_err, exp_perr);
  endtask

  initial begin
    ARESET         = 1'b1;
    bus.s_aw_pld   = '0;
    bus.s_aw_valid = 2'b00;
    bus.s_w_pld    = '0;
    bus.s_w_valid  = 2'b00;
    bus.s_b_ready  = 2'b00;
    bus.m_aw_ready = 1'b0;
    bus.m_w_ready  = 1'b0;
    bus.m_b_pld    = '0;
    bus.m_b_valid  = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_perr", proto_err, 1'b0);
    chk("rst_m_aw_valid", bus.m_aw_valid, 1'b0);
    chk("rst_s_aw_ready", bus.s_aw_ready, 2'b00);

    // Simultaneous requests right after reset: master 0 first, then master 1.
    bus.s_aw_pld[2*AWP-1:AWP] = mk_aw(4'h5, 32'h80, 8'd0);
    bus.s_aw_valid[1]         = 1'b1;
    do_txn(0, 4'hA, 32'h40, 8'd1, 1, 1'b0, 1'b0, 1'b0);
    do_txn(1, 4'h5, 32'h80, 8'd0, 0, 1'b1, 1'b0, 1'b0);

    do_txn(0, 4'h3, 32'h100, 8'd0, 0, 1'b0, 1'b0, 1'b0);
    do_txn(1, 4'h6, 32'h180, 8'd3, 3, 1'b1, 1'b1, 1'b0);
    do_txn(0, 4'h2, 32'h200, 8'd3, 1, 1'b0, 1'b0, 1'b1);

    // Async reset in the middle of a 4-beat burst.
    bus.s_aw_pld[AWP-1:0] = mk_aw(4'h7, 32'h300, 8'd3);
    bus.s_aw_valid[0]     = 1'b1;
    @(posedge ACLK); #1;
    bus.s_aw_valid[0] = 1'b0;
    bus.m_aw_ready    = 1'b1;
    @(posedge ACLK); #1;
    bus.m_aw_ready       = 1'b0;
    bus.s_w_pld[WP-1:0]  = mk_w(64'hE0, 1'b0);
    bus.s_w_valid        = 2'b01;
    bus.m_w_ready        = 1'b1;
    @(posedge ACLK); #1;
    bus.s_w_pld[WP-1:0]  = mk_w(64'hE1, 1'b0);
    #2;
    ARESET            = 1'b1;
    bus.s_aw_valid[0] = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_perr", proto_err, 1'b0);
    chk("mid_rst_m_w_valid", bus.m_w_valid, 1'b0);
    chk("mid_rst_s_w_ready", bus.s_w_ready, 2'b00);
    chk("mid_rst_s_aw_ready", bus.s_aw_ready, 2'b00);
    chk("mid_rst_m_aw_valid", bus.m_aw_valid, 1'b0);
    chk("mid_rst_s_b_valid", bus.s_b_valid, 2'b00);
    chk("mid_rst_m_b_ready", bus.m_b_ready, 1'b0);
    @(posedge ACLK); #1;
    ARESET         = 1'b0;
    bus.s_w_valid  = 2'b00;
    bus.m_w_ready  = 1'b0;
    bus.s_aw_valid = 2'b00;
    do_txn(0, 4'h9, 32'h400, 8'd0, 0, 1'b0, 1'b0, 1'b0);

    // Slave returns the wrong grant bit in bid: still routed to master 0.
    do_txn(0, 4'h4, 32'h500, 8'd0, 0, 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
